nibble_add_seq: RTL and testbench



---
 rtl/nibble_add_seq.sv | 168 ++++++++++++++++
 tb/tb_nibble_add_seq.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_add_seq.sv
// nibble_add_seq
//   Multi-cycle sequencer that forms a W = 4*NIBBLES bit sum by driving an
//   external 4-bit ripple adder one nibble per cycle, LSB nibble first.
//   Each nibble's carry-out feeds the next nibble's carry-in.
//
// Optional feature (compile-time macro NIBBLE_ADD_SUB_EN):
//   Adds op_sub (subtract request, latched with the operands) and ovf_s
//   (signed overflow of the W-bit result).
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready   request handshake carrying op_a, op_b, op_cin
//   add_a/add_b/add_cin   drive the external adder (0 outside RUN)
//   add_y/add_cout/add_zero  adder sum nibble, carry-out, nibble-zero flag
//   res_valid/res_ready   result handshake carrying result, carry_out, zero
//   fsm_state             current FSM state (IDLE=0, RUN=1, DONE=2)
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. req_ready is high only in IDLE; req_valid is ignored elsewhere.
// res_valid is high only in DONE; result/carry_out/zero stay stable until
// res_ready is seen, and res_ready is ignored outside DONE.

module nibble_add_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [4*NIBBLES-1:0]   op_a,
  input  logic [4*NIBBLES-1:0]   op_b,
  input  logic                   op_cin,
`ifdef NIBBLE_ADD_SUB_EN
  input  logic                   op_sub,
  output logic                   ovf_s,
`endif
  output logic [3:0]             add_a,
  output logic [3:0]             add_b,
  output logic                   add_cin,
  input  logic [3:0]             add_y,
  input  logic                   add_cout,
  input  logic                   add_zero,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [4*NIBBLES-1:0]   result,
  output logic                   carry_out,
  output logic                   zero,
  output logic [1:0]             fsm_state
);

  localparam int W  = 4 * NIBBLES;
  // Keep the index at least one bit wide so NIBBLES=1 still elaborates.
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [IW-1:0]   idx;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic            carry_q;
  logic            zacc_q;
`ifdef NIBBLE_ADD_SUB_EN
  logic            sub_q;
`endif

  // Bit offset of the current nibble inside the operand/result words.
  logic [IW+1:0]   base;
  assign base      = {idx, 2'b00};
  assign fsm_state = state;

  // Adder inputs: selected nibble while running, quiet zero otherwise.
  always_comb begin
    add_a   = 4'd0;
    add_b   = 4'd0;
    add_cin = 1'b0;
    if (state == RUN) begin
      add_a   = a_q[base +: 4];
`ifdef NIBBLE_ADD_SUB_EN
      // Subtraction is A + ~B + 1; the +1 sits in carry_q from acceptance.
      add_b   = b_q[base +: 4] ^ {4{sub_q}};
`else
      add_b   = b_q[base +: 4];
`endif
      add_cin = carry_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      carry_q   <= 1'b0;
      zacc_q    <= 1'b0;
      req_ready <= 1'b1;
      res_valid <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      zero      <= 1'b0;
`ifdef NIBBLE_ADD_SUB_EN
      sub_q     <= 1'b0;
      ovf_s     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            a_q       <= op_a;
            b_q       <= op_b;
            idx       <= '0;
            zacc_q    <= 1'b1;
            req_ready <= 1'b0;
            state     <= RUN;
`ifdef NIBBLE_ADD_SUB_EN
            sub_q     <= op_sub;
            carry_q   <= op_sub ? 1'b1 : op_cin;
`else
            carry_q   <= op_cin;
`endif
          end
        end

        RUN: begin
          result[base +: 4] <= add_y;
          carry_q           <= add_cout;
          zacc_q            <= zacc_q & add_zero;
          if (idx == LAST_IDX) begin
            idx       <= '0;
            carry_out <= add_cout;
            zero      <= zacc_q & add_zero;
            res_valid <= 1'b1;
            state     <= DONE;
`ifdef NIBBLE_ADD_SUB_EN
            // Overflow when both addends share a sign the result lacks;
            // add_y[3] is the result sign bit of the top nibble.
            ovf_s <= (a_q[W-1] == (b_q[W-1] ^ sub_q)) &&
                     (add_y[3] != a_q[W-1]);
`endif
          end else begin
            idx <= idx + IW'(1);
          end
        end

        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          res_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_add_seq.sv
// tb_nibble_add_seq
//   Bench for nibble_add_seq (NIBBLES=4). Supplies a behavioural 4-bit adder
//   around the sequencer, drives directed and random operations, and checks
//   each result against whole-word arithmetic. Define NIBBLE_ADD_SUB_EN to
//   also exercise subtraction and signed overflow.

module tb_nibble_add_seq;

  localparam int N = 4;
  localparam int W = 4 * N;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic           req_valid = 1'b0;
  logic           req_ready;
  logic [W-1:0]   op_a = '0;
  logic [W-1:0]   op_b = '0;
  logic           op_cin = 1'b0;
`ifdef NIBBLE_ADD_SUB_EN
  logic           op_sub = 1'b0;
  logic           ovf_s;
`endif
  logic [3:0]     add_a;
  logic [3:0]     add_b;
  logic           add_cin;
  logic [3:0]     add_y;
  logic           add_cout;
  logic           add_zero;
  logic           res_valid;
  logic           res_ready = 1'b0;
  logic [W-1:0]   result;
  logic           carry_out;
  logic           zero;
  logic [1:0]     fsm_state;

  // The 4-bit ripple adder the sequencer sits around.
  assign {add_cout, add_y} = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};
  assign add_zero          = (add_y == 4'd0);

  nibble_add_seq #(.NIBBLES(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_cin    (op_cin),
`ifdef NIBBLE_ADD_SUB_EN
    .op_sub    (op_sub),
    .ovf_s     (ovf_s),
`endif
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_y     (add_y),
    .add_cout  (add_cout),
    .add_zero  (add_zero),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .result    (result),
    .carry_out (carry_out),
    .zero      (zero),
    .fsm_state (fsm_state)
  );

  // scoreboard
  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] exp_q[$];
  logic         exp_c_q[$];
  logic         exp_z_q[$];
  logic         exp_v_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: whole-word arithmetic on the operands as numbers.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic sub);
    longint ua, ub, us, sa, sb, ss;
    ua = longint'(a);
    ub = longint'(b);
    sa = a[W-1] ? ua - (longint'(1) << W) : ua;
    sb = b[W-1] ? ub - (longint'(1) << W) : ub;
    if (sub) begin
      us = ua - ub;
      ss = sa - sb;
      exp_c_q.push_back(ua >= ub);            // carry set means no borrow
    end else begin
      us = ua + ub + longint'(cin);
      ss = sa + sb + longint'(cin);
      exp_c_q.push_back(us >= (longint'(1) << W));
    end
    exp_q.push_back(W'(us));
    exp_z_q.push_back(W'(us) == '0);
    exp_v_q.push_back((ss > (longint'(1) << (W-1)) - 1) || (ss < -(longint'(1) << (W-1))));
  endtask

  // driver: one complete operation, optional DONE back-pressure and an
  // ignored request pulse while the sequencer is busy.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic sub,
                       input int hold, input bit poke);
    int cyc;
    logic [W-1:0] r0, er;
    logic c0, z0, ec, ez, ev;
    model(a, b, cin, sub);
    for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
    check("req_ready_idle", req_ready, 1'b1);
    op_a = a; op_b = b; op_cin = cin;
`ifdef NIBBLE_ADD_SUB_EN
    op_sub = sub;
`endif
    req_valid = 1'b1;
    cyc = 0;
    // Cycle counting starts at the cycle the request is presented.
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cyc++;
      req_valid = 1'b0;
      if (poke && cyc == 2) begin
        check("req_ready_busy", req_ready, 1'b0);
        op_a = W'($urandom); op_b = W'($urandom); op_cin = 1'b1;
        req_valid = 1'b1;
      end
      if (res_valid) break;
    end
    req_valid = 1'b0;
    check("latency", cyc, N + 1);
    check("res_valid", res_valid, 1'b1);
    er = exp_q.pop_front();
    ec = exp_c_q.pop_front();
    ez = exp_z_q.pop_front();
    ev = exp_v_q.pop_front();
    check("result", result, er);
    check("carry_out", carry_out, ec);
    check("zero", zero, ez);
`ifdef NIBBLE_ADD_SUB_EN
    check("ovf_s", ovf_s, ev);
`endif
    r0 = result; c0 = carry_out; z0 = zero;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", res_valid, 1'b1);
      check("hold_result", result, r0);
      check("hold_flags", {carry_out, zero}, {c0, z0});
      check("hold_req_ready", req_ready, 1'b0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("res_valid_drop", res_valid, 1'b0);
    check("req_ready_back", req_ready, 1'b1);
    check("add_a_idle", add_a, 4'd0);
  endtask

  initial begin
    // reset
    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_result", result, '0);
    check("rst_flags", {carry_out, zero}, 2'b00);
    check("rst_add_out", {add_a, add_b, add_cin}, 9'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // directed
    do_op(16'h1234, 16'h4321, 1'b0, 1'b0, 0, 1'b0);
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0);
    do_op(16'h000F, 16'h0000, 1'b1, 1'b0, 0, 1'b1);
    do_op(16'hABCD, 16'h9876, 1'b1, 1'b0, 3, 1'b0);

    // reset in the middle of RUN, two nibbles captured
    op_a = 16'h1111; op_b = 16'h2222; op_cin = 1'b0;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_req_ready", req_ready, 1'b1);
    check("midrst_res_valid", res_valid, 1'b0);
    check("midrst_result", result, '0);
    check("midrst_flags", {carry_out, zero}, 2'b00);
    check("midrst_add_a", add_a, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_op(16'h0001, 16'h0001, 1'b0, 1'b0, 0, 1'b0);

`ifdef NIBBLE_ADD_SUB_EN
    do_op(16'h0005, 16'h0005, 1'b1, 1'b1, 0, 1'b0);
    do_op(16'h8000, 16'h0001, 1'b0, 1'b1, 1, 1'b0);
    do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0);
    do_op(16'h0003, 16'h0007, 1'b0, 1'b1, 0, 1'b0);
`endif

    // random
    for (int k = 0; k < 24; k++) begin
      logic s;
`ifdef NIBBLE_ADD_SUB_EN
      s = 1'($urandom_range(0, 1));
`else
      s = 1'b0;
`endif
      do_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), s,
            $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    // report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
